// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state codes, opcodes, mux-select constants and the per-state strobe decode.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_BNE      = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // Ready-dependent FETCH strobes (pc_write/ir_write) are added outside this decode.
  function automatic ctrl_t decode_state(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; end
      S_DECODE:  c.alu_src_b = SRCB_BROFF;
      S_MEMADR,
      S_ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_RTYPE_EX: begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_FUNCT; end
      S_RTYPE_WB: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_BEQ, S_BNE: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.branch_ne     = (s == S_BNE);
      end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; end
      S_TRAP:    c.illegal = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Opcode/handshake inputs and datapath control strobes of the multicycle control unit.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, branch_ne;
  logic             iord, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_write, reg_dst;
  logic             alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output op, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
    input  illegal, state, instr_count
  );

  modport slave (
    input  op, mem_ready,
    output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
    output illegal, state, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl_dispatch.sv
// DECODE dispatch table: opcode to the first execute state; unknown opcodes trap.
module mc_dispatch
  import multicycle_pkg::*;
#(
  parameter bit EN_EXT = 1'b1
) (
  input  logic [5:0] op_i,
  output state_e     target_o
);
  always_comb begin
    target_o = S_TRAP;
    case (op_i)
      OP_LW, OP_SW: target_o = S_MEMADR;
      OP_RTYPE:     target_o = S_RTYPE_EX;
      OP_BEQ:       target_o = S_BEQ;
      OP_J:         target_o = S_JUMP;
      OP_BNE:       target_o = EN_EXT ? S_BNE : S_TRAP;
      OP_ADDI:      target_o = EN_EXT ? S_ADDI_EX : S_TRAP;
      default:      target_o = S_TRAP;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: state register, memory wait handshake,
// registered Moore strobes and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          EN_EXT        = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.slave bus
);
  state_e           state_q, state_d, dispatch_tgt;
  ctrl_t            ctl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready, retire, fetch_rdy;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  mc_dispatch #(.EN_EXT(EN_EXT)) u_dispatch (
    .op_i     (bus.op),
    .target_o (dispatch_tgt)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE:   state_d = dispatch_tgt;
      S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (ready) state_d = S_MEMWB;
      S_MEMWR:    if (ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_BNE, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet still Moore in state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctl_q   <= decode_state(S_FETCH);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode_state(state_d);
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fetch_rdy = (state_q == S_FETCH) && ready;

  assign bus.pc_write      = ctl_q.pc_write | fetch_rdy;
  assign bus.ir_write      = fetch_rdy;
  assign bus.pc_write_cond = ctl_q.pc_write_cond;
  assign bus.branch_ne     = ctl_q.branch_ne;
  assign bus.iord          = ctl_q.iord;
  assign bus.mem_read      = ctl_q.mem_read;
  assign bus.mem_write     = ctl_q.mem_write;
  assign bus.mem_to_reg    = ctl_q.mem_to_reg;
  assign bus.reg_write     = ctl_q.reg_write;
  assign bus.reg_dst       = ctl_q.reg_dst;
  assign bus.alu_src_a     = ctl_q.alu_src_a;
  assign bus.alu_src_b     = ctl_q.alu_src_b;
  assign bus.alu_op        = ctl_q.alu_op;
  assign bus.pc_source     = ctl_q.pc_source;
  assign bus.illegal       = ctl_q.illegal;
  assign bus.state         = state_q;
  assign bus.instr_count   = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: three configurations driven with common
// stimulus, one checked per phase against an instruction-level reference model.
module tb_multicycle_ctrl;
  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                         T_BEQ = 6'b000100, T_BNE = 6'b000101, T_J = 6'b000010,
                         T_ADDI = 6'b001000;

  typedef int q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op_tb = T_R;
  logic rdy_tb = 1'b0;

  int n_assert = 0;
  int n_fail = 0;
  int sel = 0;
  int m_state = 0;
  int m_cnt = 0;
  int m_mod = 65536;
  bit m_hs = 1'b1;
  bit m_en = 1'b1;
  q_t m_path;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) A ();
  multicycle_ctrl_if #(.CNT_W(16)) B ();
  multicycle_ctrl_if #(.CNT_W(2))  C ();

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .EN_EXT(1'b1), .CNT_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(A.slave));
  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .EN_EXT(1'b0), .CNT_W(16))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(B.slave));
  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .EN_EXT(1'b1), .CNT_W(2))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(C.slave));

  assign A.op = op_tb; assign A.mem_ready = rdy_tb;
  assign B.op = op_tb; assign B.mem_ready = rdy_tb;
  assign C.op = op_tb; assign C.mem_ready = rdy_tb;

  logic [3:0]  o_state [3];
  logic [17:0] o_ctl   [3];
  logic [15:0] o_cnt   [3];

  assign o_state[0] = A.state;
  assign o_state[1] = B.state;
  assign o_state[2] = C.state;
  assign o_cnt[0] = A.instr_count;
  assign o_cnt[1] = B.instr_count;
  assign o_cnt[2] = {14'b0, C.instr_count};
  assign o_ctl[0] = {A.pc_write, A.pc_write_cond, A.branch_ne, A.iord, A.mem_read, A.mem_write,
                     A.ir_write, A.mem_to_reg, A.reg_write, A.reg_dst, A.alu_src_a,
                     A.alu_src_b, A.alu_op, A.pc_source, A.illegal};
  assign o_ctl[1] = {B.pc_write, B.pc_write_cond, B.branch_ne, B.iord, B.mem_read, B.mem_write,
                     B.ir_write, B.mem_to_reg, B.reg_write, B.reg_dst, B.alu_src_a,
                     B.alu_src_b, B.alu_op, B.pc_source, B.illegal};
  assign o_ctl[2] = {C.pc_write, C.pc_write_cond, C.branch_ne, C.iord, C.mem_read, C.mem_write,
                     C.ir_write, C.mem_to_reg, C.reg_write, C.reg_dst, C.alu_src_a,
                     C.alu_src_b, C.alu_op, C.pc_source, C.illegal};

  // States visited after DECODE for each opcode; an empty tail means back to FETCH.
  function automatic q_t path_for(logic [5:0] op);
    q_t p;
    case (op)
      T_LW:    p = '{2, 3, 4};
      T_SW:    p = '{2, 5};
      T_R:     p = '{6, 7};
      T_BEQ:   p = '{8};
      T_J:     p = '{9};
      T_BNE:   if (m_en) p = '{12}; else p = '{13};
      T_ADDI:  if (m_en) p = '{10, 11}; else p = '{13};
      default: p = '{13};
    endcase
    return p;
  endfunction

  function automatic logic [17:0] exp_ctl(int s, bit r);
    logic pcw, pcc, bne, iord, mr, mw, irw, m2r, rw, rd, sa, ill;
    logic [1:0] sb, ao, ps;
    {pcw, pcc, bne, iord, mr, mw, irw, m2r, rw, rd, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      0:  begin mr = 1; sb = 2'b01; pcw = r; irw = r; end
      1:  sb = 2'b11;
      2, 10: begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      11: rw = 1;
      8, 12: begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; bne = (s == 12); end
      9:  begin pcw = 1; ps = 2'b10; end
      13: ill = 1;
      default: ;
    endcase
    return {pcw, pcc, bne, iord, mr, mw, irw, m2r, rw, rd, sa, sb, ao, ps, ill};
  endfunction

  task automatic check_all(input bit r);
    logic [3:0]  os;
    logic [17:0] oc, ec;
    logic [15:0] on;
    os = o_state[sel];
    oc = o_ctl[sel];
    on = o_cnt[sel];
    ec = exp_ctl(m_state, r);
    n_assert++;
    assert (os === 4'(m_state))
      else begin n_fail++; $error("FAIL state: observed %0d expected %0d", os, m_state); end
    n_assert++;
    assert (oc === ec)
      else begin n_fail++; $error("FAIL ctrl[st%0d]: observed %b expected %b", m_state, oc, ec); end
    n_assert++;
    assert (on === 16'(m_cnt))
      else begin n_fail++; $error("FAIL instr_count: observed %0d expected %0d", on, m_cnt); end
  endtask

  // One clock: drive ready, check at negedge, advance the model at posedge.
  task automatic step(input bit rdy);
    bit r;
    rdy_tb = rdy;
    @(negedge clk);
    r = m_hs ? rdy : 1'b1;
    check_all(r);
    @(posedge clk);
    if (m_state == 0) begin
      if (r) begin m_path = path_for(op_tb); m_state = 1; end
    end else if (m_state == 13) begin
      m_state = 13;
    end else if ((m_state == 3 || m_state == 5) && !r) begin
      m_state = m_state;
    end else if (m_path.size() > 0) begin
      m_state = m_path.pop_front();
    end else begin
      m_state = 0;
      m_cnt = (m_cnt + 1) % m_mod;
    end
    #1;
  endtask

  function automatic bit rdy_pick(int mode);
    return (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endfunction

  task automatic timeout(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  task automatic issue(input logic [5:0] op, input int mode);
    int k;
    k = 0;
    while (m_state != 0 && m_state != 13 && k < 60) begin step(rdy_pick(mode)); k++; end
    op_tb = op;
    while (m_state == 0 && k < 60) begin step(rdy_pick(mode)); k++; end
    while (m_state != 0 && m_state != 13 && k < 60) begin step(rdy_pick(mode)); k++; end
    if (k >= 60) timeout("issue");
  endtask

  task automatic do_reset();
    rdy_tb = 1'b0;
    rst_n = 1'b0;
    #1;
    m_state = 0;
    m_cnt = 0;
    m_path.delete();
    check_all(m_hs ? 1'b0 : 1'b1);
    #2;
    rst_n = 1'b1;
  endtask

  logic [5:0] legal [7];
  int cseq [5];

  initial begin
    legal = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI};
    cseq = '{1, 2, 3, 0, 1};

    // Phase A: full configuration
    sel = 0; m_hs = 1; m_en = 1; m_mod = 65536;
    #6;
    do_reset();
    step(0);
    issue(T_LW, 0);
    op_tb = T_SW;
    step(1); step(1); step(1); step(0); step(0); step(1);
    issue(T_BEQ, 0);
    issue(T_BNE, 0);
    issue(T_J, 0);
    for (int i = 0; i < 30; i++) issue(legal[$urandom_range(0, 6)], 1);

    op_tb = T_R;
    for (int i = 0; i < 10 && m_state != 0; i++) step(1);
    for (int i = 0; i < 10 && m_state != 6; i++) step(1);
    if (m_state != 6) timeout("reach RTYPE_EX");
    do_reset();
    step(0);
    issue(T_LW, 0);
    issue(T_ADDI, 1);

    // Phase B: no extensions, handshake ignored
    sel = 1; m_hs = 0; m_en = 0; m_mod = 65536;
    op_tb = T_R;
    do_reset();
    issue(T_BEQ, 1);
    issue(T_ADDI, 1);
    for (int i = 0; i < 20; i++) step(rdy_pick(1));

    // Phase C: 2-bit counter wrap
    sel = 2; m_hs = 1; m_en = 1; m_mod = 4;
    do_reset();
    step(0);
    for (int i = 0; i < 5; i++) begin
      issue(T_R, 0);
      n_assert++;
      assert (o_cnt[2] === 16'(cseq[i]))
        else begin n_fail++; $error("FAIL cnt_wrap[%0d]: observed %0d expected %0d", i, o_cnt[2], cseq[i]); end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected $finish");
    $fatal(1, "watchdog");
  end
endmodule
